ghost_collision_manager: RTL and testbench

- Sits directly downstream of the ghost movement controllers and the player controller.
- Compares the tile-aligned player position against every ghost position and detects catches.
- Runs the life/death sequence and freezes the movers during it.
- Drives an active-low respawn strobe back into the mover resets; flags game over when lives run out.

---
 rtl/ghost_collision_manager_pkg.sv | 39 +++
 rtl/ghost_hit_finder.sv | 60 ++++++
 rtl/ghost_collision_manager.sv | 166 ++++++++++++++++
 tb/tb_ghost_collision_manager.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_collision_manager_pkg.sv
//------------------------------------------------------------------------------
// ghost_collision_manager_pkg : shared widths and state encoding for the
// ghost collision manager. Optional feature macro: SWAP_DETECT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif

package ghost_collision_manager_pkg;

  localparam int LIVES_W = 3;
  localparam int X_W     = $clog2(`WIDTH);
  localparam int Y_W     = $clog2(`HEIGHT);

  localparam logic [2:0] ST_PLAYING   = 3'd0;
  localparam logic [2:0] ST_HIT       = 3'd1;
  localparam logic [2:0] ST_FREEZE    = 3'd2;
  localparam logic [2:0] ST_RESPAWN   = 3'd3;
  localparam logic [2:0] ST_GUARD     = 3'd4;
  localparam logic [2:0] ST_GAME_OVER = 3'd5;

  typedef enum logic [2:0] {
    S_PLAYING   = ST_PLAYING,
    S_HIT       = ST_HIT,
    S_FREEZE    = ST_FREEZE,
    S_RESPAWN   = ST_RESPAWN,
    S_GUARD     = ST_GUARD,
    S_GAME_OVER = ST_GAME_OVER
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ghost_hit_finder.sv
//------------------------------------------------------------------------------
// ghost_hit_finder : per-ghost position compare with lowest-index priority.
// Optional feature macro: SWAP_DETECT_EN (adds head-on pass-through compare).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ghost_hit_finder
  import ghost_collision_manager_pkg::*;
#(
  parameter int NUM_GHOSTS = 4
) (
  input  logic [X_W-1:0]                  player_x,
  input  logic [Y_W-1:0]                  player_y,
  input  logic [NUM_GHOSTS*X_W-1:0]       ghost_x_bus,
  input  logic [NUM_GHOSTS*Y_W-1:0]       ghost_y_bus,
`ifdef SWAP_DETECT_EN
  input  logic                            swap_check,
  input  logic [X_W-1:0]                  prev_player_x,
  input  logic [Y_W-1:0]                  prev_player_y,
  input  logic [NUM_GHOSTS*X_W-1:0]       prev_ghost_x_bus,
  input  logic [NUM_GHOSTS*Y_W-1:0]       prev_ghost_y_bus,
`endif
  output logic                            any_hit,
  output logic [$clog2(NUM_GHOSTS)-1:0]   hit_idx
);

  localparam int ID_W = $clog2(NUM_GHOSTS);

  logic [NUM_GHOSTS-1:0] w_match;

  for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_cmp
    logic w_overlap;
    assign w_overlap = (ghost_x_bus[gi*X_W +: X_W] == player_x) &&
                       (ghost_y_bus[gi*Y_W +: Y_W] == player_y);
`ifdef SWAP_DETECT_EN
    // Player and ghost traded tiles on this step, so they passed through each other.
    logic w_swap;
    assign w_swap = swap_check &&
                    (prev_ghost_x_bus[gi*X_W +: X_W] == player_x) &&
                    (prev_ghost_y_bus[gi*Y_W +: Y_W] == player_y) &&
                    (ghost_x_bus[gi*X_W +: X_W] == prev_player_x) &&
                    (ghost_y_bus[gi*Y_W +: Y_W] == prev_player_y);
    assign w_match[gi] = w_overlap | w_swap;
`else
    assign w_match[gi] = w_overlap;
`endif
  end

  always_comb begin
    any_hit = |w_match;
    hit_idx = '0;
    for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
      if (w_match[i]) hit_idx = ID_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ghost_collision_manager.sv
//------------------------------------------------------------------------------
// ghost_collision_manager : catch detection and life/death sequencing.
// Optional feature macro: SWAP_DETECT_EN.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ghost_collision_manager
  import ghost_collision_manager_pkg::*;
#(
  parameter int NUM_GHOSTS     = 4,
  parameter int START_LIVES    = 3,
  parameter int FREEZE_TICKS   = 30,
  parameter int RESPAWN_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            move_tick,
  input  logic [X_W-1:0]                  player_x,
  input  logic [Y_W-1:0]                  player_y,
  input  logic [NUM_GHOSTS*X_W-1:0]       ghost_x_bus,
  input  logic [NUM_GHOSTS*Y_W-1:0]       ghost_y_bus,
  input  logic                            restart,
  output logic                            hit,
  output logic [$clog2(NUM_GHOSTS)-1:0]   hit_id,
  output logic [LIVES_W-1:0]              lives,
  output logic                            freeze,
  output logic                            respawn_n,
  output logic                            game_over
);

  localparam int ID_W = $clog2(NUM_GHOSTS);
  localparam int FT_W = $clog2(FREEZE_TICKS + 1);
  localparam int RC_W = $clog2(RESPAWN_CYCLES + 1);
  localparam logic [FT_W-1:0]    C_FT_LAST     = FT_W'(FREEZE_TICKS - 1);
  localparam logic [RC_W-1:0]    C_RC_LAST     = RC_W'(RESPAWN_CYCLES - 1);
  localparam logic [LIVES_W-1:0] C_START_LIVES = LIVES_W'(START_LIVES);

  state_t             r_state, w_state_nxt;
  logic [FT_W-1:0]    r_frz_cnt, w_frz_cnt_nxt;
  logic [RC_W-1:0]    r_rsp_cnt, w_rsp_cnt_nxt;
  logic [LIVES_W-1:0] r_lives, w_lives_nxt;
  logic [ID_W-1:0]    r_hit_id, w_hit_id_nxt;
  logic               w_any_hit;
  logic [ID_W-1:0]    w_hit_idx;

`ifdef SWAP_DETECT_EN
  logic [X_W-1:0]            r_prev_px;
  logic [Y_W-1:0]            r_prev_py;
  logic [NUM_GHOSTS*X_W-1:0] r_prev_gx;
  logic [NUM_GHOSTS*Y_W-1:0] r_prev_gy;
  logic                      w_prev_load;

  // GUARD seeds the history with the movers' freshly reset positions.
  assign w_prev_load = ((r_state == S_PLAYING) && move_tick) || (r_state == S_GUARD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_px <= '0;
      r_prev_py <= '0;
      r_prev_gx <= '0;
      r_prev_gy <= '0;
    end else if (w_prev_load) begin
      r_prev_px <= player_x;
      r_prev_py <= player_y;
      r_prev_gx <= ghost_x_bus;
      r_prev_gy <= ghost_y_bus;
    end
  end
`endif

  ghost_hit_finder #(
    .NUM_GHOSTS       (NUM_GHOSTS)
  ) u_hit_finder (
    .player_x         (player_x),
    .player_y         (player_y),
    .ghost_x_bus      (ghost_x_bus),
    .ghost_y_bus      (ghost_y_bus),
`ifdef SWAP_DETECT_EN
    .swap_check       (move_tick),
    .prev_player_x    (r_prev_px),
    .prev_player_y    (r_prev_py),
    .prev_ghost_x_bus (r_prev_gx),
    .prev_ghost_y_bus (r_prev_gy),
`endif
    .any_hit          (w_any_hit),
    .hit_idx          (w_hit_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_PLAYING;
      r_frz_cnt <= '0;
      r_rsp_cnt <= '0;
      r_lives   <= C_START_LIVES;
      r_hit_id  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_frz_cnt <= w_frz_cnt_nxt;
      r_rsp_cnt <= w_rsp_cnt_nxt;
      r_lives   <= w_lives_nxt;
      r_hit_id  <= w_hit_id_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_frz_cnt_nxt = r_frz_cnt;
    w_rsp_cnt_nxt = r_rsp_cnt;
    w_lives_nxt   = r_lives;
    w_hit_id_nxt  = r_hit_id;
    case (r_state)
      S_PLAYING: begin
        if (w_any_hit) begin
          w_state_nxt  = S_HIT;
          w_hit_id_nxt = w_hit_idx;
        end
      end
      S_HIT: begin
        w_lives_nxt = (r_lives == '0) ? '0 : r_lives - 1'b1;
        w_state_nxt = S_FREEZE;
      end
      S_FREEZE: begin
        if (move_tick) begin
          if (r_frz_cnt == C_FT_LAST) begin
            w_frz_cnt_nxt = '0;
            w_state_nxt   = (r_lives == '0) ? S_GAME_OVER : S_RESPAWN;
          end else begin
            w_frz_cnt_nxt = r_frz_cnt + 1'b1;
          end
        end
      end
      S_RESPAWN: begin
        if (r_rsp_cnt == C_RC_LAST) begin
          w_rsp_cnt_nxt = '0;
          w_state_nxt   = S_GUARD;
        end else begin
          w_rsp_cnt_nxt = r_rsp_cnt + 1'b1;
        end
      end
      S_GUARD: begin
        w_state_nxt = S_PLAYING;
      end
      S_GAME_OVER: begin
        if (restart) begin
          w_lives_nxt = C_START_LIVES;
          w_state_nxt = S_RESPAWN;
        end
      end
      default: begin
        w_state_nxt = S_PLAYING;
      end
    endcase
  end

  // Outputs decode straight from the state register so async reset clears them at once.
  assign hit       = (r_state == S_HIT);
  assign freeze    = (r_state == S_FREEZE) || (r_state == S_RESPAWN) ||
                     (r_state == S_GAME_OVER);
  assign respawn_n = (r_state != S_RESPAWN);
  assign game_over = (r_state == S_GAME_OVER);
  assign lives     = r_lives;
  assign hit_id    = r_hit_id;

endmodule

`default_nettype wire

// File: tb/tb_ghost_collision_manager.sv
//------------------------------------------------------------------------------
// tb_ghost_collision_manager : directed stimulus, behavioural model, literal checks.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ghost_collision_manager;
  import ghost_collision_manager_pkg::*;

  localparam int NG   = 4;
  localparam int SL   = 3;
  localparam int FT   = 30;
  localparam int RC   = 2;
  localparam int IDW  = $clog2(NG);

  localparam int M_PLAY = 0, M_HIT = 1, M_FRZ = 2, M_RSP = 3, M_GRD = 4, M_OVER = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic move_tick = 1'b0;
  logic restart = 1'b0;
  logic [X_W-1:0] player_x = '0;
  logic [Y_W-1:0] player_y = '0;
  logic [X_W-1:0] gx [NG];
  logic [Y_W-1:0] gy [NG];
  logic [NG*X_W-1:0] ghost_x_bus;
  logic [NG*Y_W-1:0] ghost_y_bus;
  logic hit, freeze, respawn_n, game_over;
  logic [IDW-1:0] hit_id;
  logic [LIVES_W-1:0] lives;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NG; i++) begin
      ghost_x_bus[i*X_W +: X_W] = gx[i];
      ghost_y_bus[i*Y_W +: Y_W] = gy[i];
    end
  end

  ghost_collision_manager #(
    .NUM_GHOSTS(NG), .START_LIVES(SL), .FREEZE_TICKS(FT), .RESPAWN_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset), .move_tick(move_tick),
    .player_x(player_x), .player_y(player_y),
    .ghost_x_bus(ghost_x_bus), .ghost_y_bus(ghost_y_bus),
    .restart(restart), .hit(hit), .hit_id(hit_id), .lives(lives),
    .freeze(freeze), .respawn_n(respawn_n), .game_over(game_over)
  );

  // Behavioural model: phase + countdown of remaining ticks/cycles.
  int m_mode, m_lives, m_id, m_left;
  int pp_x, pp_y;
  int pg_x [NG];
  int pg_y [NG];

  function automatic int catcher();
    bit same, swap;
    for (int i = 0; i < NG; i++) begin
      same = (gx[i] == player_x) && (gy[i] == player_y);
      swap = 1'b0;
`ifdef SWAP_DETECT_EN
      swap = move_tick && (int'(player_x) == pg_x[i]) && (int'(player_y) == pg_y[i]) &&
             (int'(gx[i]) == pp_x) && (int'(gy[i]) == pp_y);
`endif
      if (same || swap) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= M_PLAY; m_lives <= SL; m_id <= 0; m_left <= 0;
      pp_x <= 0; pp_y <= 0;
      for (int i = 0; i < NG; i++) begin pg_x[i] <= 0; pg_y[i] <= 0; end
    end else begin
      case (m_mode)
        M_PLAY: begin
          if (catcher() >= 0) begin m_mode <= M_HIT; m_id <= catcher(); end
          if (move_tick) begin
            pp_x <= int'(player_x); pp_y <= int'(player_y);
            for (int i = 0; i < NG; i++) begin pg_x[i] <= int'(gx[i]); pg_y[i] <= int'(gy[i]); end
          end
        end
        M_HIT: begin
          m_lives <= (m_lives > 0) ? m_lives - 1 : 0;
          m_mode <= M_FRZ; m_left <= FT;
        end
        M_FRZ: if (move_tick) begin
          if (m_left == 1) begin
            m_mode <= (m_lives == 0) ? M_OVER : M_RSP; m_left <= RC;
          end else m_left <= m_left - 1;
        end
        M_RSP: begin
          if (m_left == 1) m_mode <= M_GRD; else m_left <= m_left - 1;
        end
        M_GRD: begin
          m_mode <= M_PLAY;
          pp_x <= int'(player_x); pp_y <= int'(player_y);
          for (int i = 0; i < NG; i++) begin pg_x[i] <= int'(gx[i]); pg_y[i] <= int'(gy[i]); end
        end
        default: if (restart) begin m_lives <= SL; m_mode <= M_RSP; m_left <= RC; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on && reset) begin
      total++;
      if (hit !== (m_mode == M_HIT) || hit_id !== IDW'(m_id) || lives !== LIVES_W'(m_lives) ||
          freeze !== (m_mode == M_FRZ || m_mode == M_RSP || m_mode == M_OVER) ||
          respawn_n !== (m_mode != M_RSP) || game_over !== (m_mode == M_OVER)) begin
        bad++;
        $display("FAIL model_cmp t=%0t hit=%b id=%0d lives=%0d frz=%b rsp_n=%b go=%b required mode=%0d id=%0d lives=%0d",
                 $time, hit, hit_id, lives, freeze, respawn_n, game_over, m_mode, m_id, m_lives);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic park(input int i);
    gx[i] = X_W'(300 + 20 * i);
    gy[i] = Y_W'(300);
  endtask

  // Counts consecutive respawn_n-low cycles starting at an already-low cycle.
  task automatic measure_respawn(input string name);
    int n;
    n = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (respawn_n) break;
      n++;
    end
    check(name, n, RC);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    player_x = X_W'(100); player_y = Y_W'(200);
    for (int i = 0; i < NG; i++) park(i);
    #12;
    check("rst_lives", int'(lives), 3);
    check("rst_freeze", int'(freeze), 0);
    check("rst_respawn_n", int'(respawn_n), 1);
    check("rst_game_over", int'(game_over), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_hit_id", int'(hit_id), 0);
    @(negedge clk);
    reset = 1'b1; chk_on = 1'b1;
    cyc(2);

    // Ghost 2 catches the player.
    gx[2] = X_W'(100); gy[2] = Y_W'(200);
    @(negedge clk);
    check("t1_hit", int'(hit), 1);
    check("t1_hit_id", int'(hit_id), 2);
    park(2);
    @(negedge clk);
    check("t1_freeze", int'(freeze), 1);
    check("t1_lives", int'(lives), 2);
    check("t1_hit_pulse_end", int'(hit), 0);
    for (int k = 0; k < FT - 1; k++) tick();
    check("t1_frozen_after_29", int'(freeze), 1);
    check("t1_no_early_respawn", int'(respawn_n), 1);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    check("t1_respawn_low", int'(respawn_n), 0);
    measure_respawn("t1_respawn_len");
    check("t1_guard_freeze", int'(freeze), 0);
    @(negedge clk);
    check("t1_play_freeze", int'(freeze), 0);

    // Restart outside GAME_OVER must be ignored.
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
    check("restart_ignored", int'(respawn_n), 1);

    // Ghosts 1 and 3 together: one hit, lowest index.
    gx[1] = X_W'(100); gy[1] = Y_W'(200);
    gx[3] = X_W'(100); gy[3] = Y_W'(200);
    @(negedge clk);
    check("t2_hit_id", int'(hit_id), 1);
    park(1); park(3);
    @(negedge clk);
    check("t2_lives", int'(lives), 1);
    for (int k = 0; k < FT; k++) tick();
    cyc(RC + 2);

    // Final life lost -> GAME_OVER without respawn.
    gx[0] = X_W'(100); gy[0] = Y_W'(200);
    @(negedge clk);
    check("t3_hit_id", int'(hit_id), 0);
    park(0);
    @(negedge clk);
    check("t3_lives", int'(lives), 0);
    for (int k = 0; k < FT; k++) tick();
    check("t3_game_over", int'(game_over), 1);
    check("t3_freeze", int'(freeze), 1);
    check("t3_no_respawn", int'(respawn_n), 1);
    cyc(5);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("t3_restart_lives", int'(lives), 3);
    check("t3_restart_go", int'(game_over), 0);
    check("t3_restart_respawn", int'(respawn_n), 0);
    measure_respawn("t3_respawn_len");
    cyc(2);

    // Async reset in the middle of FREEZE.
    gx[2] = X_W'(100); gy[2] = Y_W'(200);
    @(negedge clk);
    park(2);
    tick(); tick(); tick();
    check("t4_pre_freeze", int'(freeze), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t4_freeze", int'(freeze), 0);
    check("t4_lives", int'(lives), 3);
    check("t4_hit_id", int'(hit_id), 0);
    check("t4_respawn_n", int'(respawn_n), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t4_playing", int'(freeze), 0);
    cyc(2);

    // Head-on pass-through between player and ghost 0.
    player_x = X_W'(40); player_y = Y_W'(20);
    gx[0] = X_W'(60); gy[0] = Y_W'(20);
    move_tick = 1'b1;
    @(negedge clk);
    player_x = X_W'(60);
    gx[0] = X_W'(40);
    @(negedge clk);
    move_tick = 1'b0;
`ifdef SWAP_DETECT_EN
    check("t5_swap_hit", int'(hit), 1);
    check("t5_swap_id", int'(hit_id), 0);
`else
    check("t5_no_swap_hit", int'(hit), 0);
    check("t5_no_swap_id", int'(hit_id), 0);
`endif
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
